// File: rtl/cla_pkg.sv
// cla_pkg: controller state encoding and default geometry shared by the sequential CLA adder.
`default_nettype none

package cla_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int CLA_WIDTH = 64;
  localparam int CLA_SLICE = 16;
  localparam int CLA_GROUP = 4;

endpackage

`default_nettype wire

// File: rtl/cla_slice_add.sv
// cla_slice_add: combinational SLICE-bit carry-lookahead adder built from 4-bit lookahead groups.
`default_nettype none

module cla_slice_add
  import cla_pkg::*;
#(
  parameter int SLICE = CLA_SLICE
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             c_i,
  output logic [SLICE-1:0] s,
  output logic             c_o,
  output logic             c_msb
);

  localparam int NGRP = SLICE / CLA_GROUP;

  logic [SLICE-1:0] g;
  logic [SLICE-1:0] p;
  logic [SLICE-1:0] ci;
  logic [NGRP-1:0]  gg;
  logic [NGRP-1:0]  gp;
  logic [NGRP:0]    cg;

  generate
    if (SLICE % CLA_GROUP != 0 || SLICE < CLA_GROUP) begin : g_bad_slice
      $error("cla_slice_add: SLICE must be a positive multiple of 4");
    end
  endgenerate

  assign g = a & b;
  assign p = a ^ b;

  generate
    for (genvar k = 0; k < NGRP; k++) begin : g_grp
      localparam int B = k * CLA_GROUP;
      // Carries inside a group are fully expanded from the group's carry-in.
      assign ci[B]   = cg[k];
      assign ci[B+1] = g[B] | (p[B] & cg[k]);
      assign ci[B+2] = g[B+1] | (p[B+1] & g[B]) | (p[B+1] & p[B] & cg[k]);
      assign ci[B+3] = g[B+2] | (p[B+2] & g[B+1]) | (p[B+2] & p[B+1] & g[B])
                     | (p[B+2] & p[B+1] & p[B] & cg[k]);
      assign gg[k]   = g[B+3] | (p[B+3] & g[B+2]) | (p[B+3] & p[B+2] & g[B+1])
                     | (p[B+3] & p[B+2] & p[B+1] & g[B]);
      assign gp[k]   = &p[B+3:B];
    end
  endgenerate

  always_comb begin
    cg[0] = c_i;
    for (int k = 0; k < NGRP; k++) begin
      cg[k+1] = gg[k] | (gp[k] & cg[k]);
    end
  end

  assign s     = p ^ ci;
  assign c_o   = cg[NGRP];
  assign c_msb = ci[SLICE-1];

endmodule

`default_nettype wire

// File: rtl/cla_wide_seq_adder.sv
// cla_wide_seq_adder: WIDTH-bit add/sub computed one SLICE-bit CLA pass per clock, LSB slice first,
// with valid/ready handshakes on operands and result.
`default_nettype none

module cla_wide_seq_adder
  import cla_pkg::*;
#(
  parameter int WIDTH = CLA_WIDTH,
  parameter int SLICE = CLA_SLICE
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             op_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICE - 1);

  generate
    if (WIDTH % SLICE != 0 || NSLICE < 2) begin : g_bad_geometry
      $error("cla_wide_seq_adder: WIDTH must be a multiple of SLICE with at least two slices");
    end
  endgenerate

  state_e state_q, state_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic carry_q, carry_d;
  logic c_msb_q, c_msb_d;
  logic op_sub_q, op_sub_d;
  logic [NSLICE-1:0][SLICE-1:0] a_q, a_d;
  logic [NSLICE-1:0][SLICE-1:0] b_q, b_d;
  logic [NSLICE-1:0][SLICE-1:0] sum_q, sum_d;

  logic [SLICE-1:0] slice_s;
  logic             slice_co;
  logic             slice_msb;

  cla_slice_add #(
    .SLICE (SLICE)
  ) u_slice (
    .a     (a_q[idx_q]),
    .b     (b_q[idx_q]),
    .c_i   (carry_q),
    .s     (slice_s),
    .c_o   (slice_co),
    .c_msb (slice_msb)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      c_msb_q  <= 1'b0;
      op_sub_q <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      sum_q    <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      carry_q  <= carry_d;
      c_msb_q  <= c_msb_d;
      op_sub_q <= op_sub_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sum_q    <= sum_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    carry_d  = carry_q;
    c_msb_d  = c_msb_q;
    op_sub_d = op_sub_q;
    a_d      = a_q;
    b_d      = b_q;
    sum_d    = sum_q;
    case (state_q)
      ST_IDLE: begin
        // Subtraction is a + ~b + ~c_in; the borrow is recovered on the way out.
        if (in_valid) begin
          a_d      = a;
          b_d      = op_sub ? ~b : b;
          op_sub_d = op_sub;
          carry_d  = c_in ^ op_sub;
          idx_d    = '0;
          state_d  = ST_RUN;
        end
      end
      ST_RUN: begin
        sum_d[idx_q] = slice_s;
        carry_d      = slice_co;
        idx_d        = idx_q + IDXW'(1);
        if (idx_q == LAST_IDX) begin
          c_msb_d = slice_msb;
          idx_d   = '0;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign sum       = out_valid ? sum_q : '0;
  assign c_out     = out_valid & (carry_q ^ op_sub_q);
  assign ovf       = out_valid & (carry_q ^ c_msb_q);

endmodule

`default_nettype wire
